// File: rtl/dice_roll_ctrl.sv
// Two-player dice roll controller: round-robin grant, tick-paced roll animation,
// hold period and per-player saturating score accumulation.
module dice_roll_ctrl #(
  parameter int ROLL_TICKS = 8,
  parameter int HOLD_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_roll,
  input  logic       clr_scores,
  input  logic       tick,
  input  logic [2:0] numero_in,
  output logic [2:0] dado,
  output logic       rolling,
  output logic       done,
  output logic       player,
  output logic [7:0] score0,
  output logic [7:0] score1
);

  typedef enum logic [1:0] {IDLE, ROLL, HOLD} state_t;

  localparam logic [7:0] ROLL_MAX  = 8'(ROLL_TICKS);
  localparam logic [7:0] ROLL_LAST = 8'(ROLL_TICKS - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);

  state_t     state_reg, state_next;
  logic [1:0] btn_prev_reg;
  logic [1:0] pend_reg, pend_next;
  logic [1:0] btn_edge;
  logic [7:0] cnt_reg;
  logic [2:0] dado_reg;
  logic       done_reg;
  logic       player_reg;
  logic       prio_reg;
  logic [7:0] score_reg [2];

  logic numero_valid;
  logic grant_valid;
  logic grant_id;
  logic final_tick;
  logic hold_last;

  assign numero_valid = (numero_in != 3'd0) && (numero_in != 3'd7);
  assign btn_edge     = btn_roll & ~btn_prev_reg;

  always_comb begin
    grant_valid = (state_reg == IDLE) && (pend_reg != 2'b00);
    grant_id    = (pend_reg == 2'b11) ? prio_reg : pend_reg[1];
    // A saturated counter still needs a valid value before the roll can end.
    final_tick  = (state_reg == ROLL) && tick && (cnt_reg >= ROLL_LAST) && numero_valid;
    hold_last   = (state_reg == HOLD) && tick && (cnt_reg == HOLD_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = ROLL;
      ROLL:    if (final_tick)  state_next = HOLD;
      HOLD:    if (hold_last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rolling = (state_reg == ROLL);
  end

  assign dado   = dado_reg;
  assign done   = done_reg;
  assign player = player_reg;
  assign score0 = score_reg[0];
  assign score1 = score_reg[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_reg <= btn_roll;
      cnt_reg      <= 8'd0;
      dado_reg     <= 3'd0;
      done_reg     <= 1'b0;
      player_reg   <= 1'b0;
      prio_reg     <= 1'b0;
    end else begin
      btn_prev_reg <= btn_roll;
      done_reg     <= final_tick;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            player_reg <= grant_id;
            cnt_reg    <= 8'd0;
          end
        end
        ROLL: begin
          if (tick) begin
            if (numero_valid) dado_reg <= numero_in;
            if (final_tick)              cnt_reg <= 8'd0;
            else if (cnt_reg != ROLL_MAX) cnt_reg <= cnt_reg + 8'd1;
          end
        end
        HOLD: begin
          if (tick) begin
            if (hold_last) begin
              cnt_reg  <= 8'd0;
              prio_reg <= ~player_reg;
            end else begin
              cnt_reg <= cnt_reg + 8'd1;
            end
          end
        end
        default: cnt_reg <= 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend_reg <= 2'b00;
    else     pend_reg <= pend_next;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_player
      logic       ignore_edge;
      logic       clear_pend;
      logic [8:0] sum;
      logic [7:0] sum_sat;

      // The active player's own presses are dropped until its turn ends.
      assign ignore_edge   = (state_reg != IDLE) && (player_reg == 1'(gi));
      assign clear_pend    = grant_valid && (grant_id == 1'(gi));
      assign pend_next[gi] = (pend_reg[gi] && !clear_pend) || (btn_edge[gi] && !ignore_edge);

      assign sum     = {1'b0, score_reg[gi]} + {6'd0, numero_in};
      assign sum_sat = sum[8] ? 8'hFF : sum[7:0];

      always_ff @(posedge clk) begin
        if (rst || clr_scores)
          score_reg[gi] <= 8'd0;
        else if (final_tick && (player_reg == 1'(gi)))
          score_reg[gi] <= sum_sat;
      end
    end
  endgenerate

endmodule
